// File: rtl/axi_pkg.sv
// Shared AXI4 types and constants for the manager block and its helpers.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  localparam logic [2:0] SIZE_8B = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5
  } mgr_state_t;

  // Response codes are ordered by severity, so the worst one is the numeric max.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    resp_max = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_beat_tracker.sv
// Beat counter shared by the W and R phases; saturates at 255 and flags the
// beat whose index equals the burst length.
module axi_beat_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       step,
  input  logic [7:0] len,
  output logic       is_last
);

  logic [7:0] beat_r;
  logic       ovf_r;

  // Beat count and overflow flag; once past 255 no beat can be the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_r <= 8'd0;
      ovf_r  <= 1'b0;
    end else if (clear) begin
      beat_r <= 8'd0;
      ovf_r  <= 1'b0;
    end else if (step) begin
      if (beat_r == 8'hFF) begin
        ovf_r <= 1'b1;
      end else begin
        beat_r <= beat_r + 8'd1;
      end
    end
  end

  assign is_last = (beat_r == len) && !ovf_r;

endmodule

// File: rtl/axi_manager.sv
// Single-outstanding AXI4 manager: one INCR burst per local command, with
// pass-through W/R data paths and a registered completion report.
module axi_manager
  import axi_pkg::*;
#(
  parameter int ID_W   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        rd_resp,
  output logic              rd_last,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              done,
  output logic [1:0]        done_resp,
  output logic              done_err,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [ID_W-1:0]   AWID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [ID_W-1:0]   BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY
);

  mgr_state_t        state_r, state_next_s;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        len_r;
  logic [ID_W-1:0]   id_r;
  logic              cmd_ready_r, arvalid_r, awvalid_r, bready_r;
  logic [1:0]        resp_r, resp_next_s, done_resp_r;
  logic              err_r, err_next_s, done_r, done_err_r;
  logic              cmd_accept_s, r_hs_s, w_hs_s, b_hs_s, finish_s, is_last_s;

  assign cmd_accept_s = (state_r == ST_IDLE) && cmd_valid;
  assign r_hs_s       = (state_r == ST_R) && RVALID && rd_ready;
  assign w_hs_s       = (state_r == ST_W) && wr_valid && WREADY;
  assign b_hs_s       = bready_r && BVALID;
  assign finish_s     = (r_hs_s && RLAST) || b_hs_s;

  axi_beat_tracker u_beats (
    .clk     (clk),
    .rst     (rst),
    .clear   (cmd_accept_s),
    .step    (r_hs_s || w_hs_s),
    .len     (len_r),
    .is_last (is_last_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; a read ends only on RLAST, however many beats arrive.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) state_next_s = cmd_write ? ST_AW : ST_AR;
        else           state_next_s = ST_IDLE;
      end
      ST_AR: begin
        if (ARREADY) state_next_s = ST_R;
        else         state_next_s = ST_AR;
      end
      ST_R: begin
        if (r_hs_s && RLAST) state_next_s = ST_IDLE;
        else                 state_next_s = ST_R;
      end
      ST_AW: begin
        if (AWREADY) state_next_s = ST_W;
        else         state_next_s = ST_AW;
      end
      ST_W: begin
        if (w_hs_s && is_last_s) state_next_s = ST_B;
        else                     state_next_s = ST_W;
      end
      ST_B: begin
        if (BVALID) state_next_s = ST_IDLE;
        else        state_next_s = ST_B;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Response/error accumulation for the beat or write response in flight.
  always_comb begin
    resp_next_s = resp_r;
    err_next_s  = err_r;
    if (r_hs_s) begin
      resp_next_s = resp_max(resp_r, RRESP);
      err_next_s  = err_r || (RID != id_r) || (RLAST != is_last_s);
    end else if (b_hs_s) begin
      resp_next_s = BRESP;
      err_next_s  = err_r || (BID != id_r);
    end else begin
      resp_next_s = resp_r;
      err_next_s  = err_r;
    end
  end

  // Registered handshake outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready_r <= 1'b1;
      arvalid_r   <= 1'b0;
      awvalid_r   <= 1'b0;
      bready_r    <= 1'b0;
    end else begin
      cmd_ready_r <= (state_next_s == ST_IDLE);
      arvalid_r   <= (state_next_s == ST_AR);
      awvalid_r   <= (state_next_s == ST_AW);
      bready_r    <= (state_next_s == ST_B);
    end
  end

  // Command latch, accumulators and completion report.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r      <= '0;
      len_r       <= 8'd0;
      id_r        <= '0;
      resp_r      <= 2'b00;
      err_r       <= 1'b0;
      done_r      <= 1'b0;
      done_resp_r <= 2'b00;
      done_err_r  <= 1'b0;
    end else begin
      done_r <= finish_s;
      if (cmd_accept_s) begin
        addr_r <= cmd_addr;
        len_r  <= cmd_len;
        id_r   <= cmd_id;
        resp_r <= 2'b00;
        err_r  <= 1'b0;
      end else begin
        resp_r <= resp_next_s;
        err_r  <= err_next_s;
      end
      if (finish_s) begin
        done_resp_r <= resp_next_s;
        done_err_r  <= err_next_s;
      end
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign done      = done_r;
  assign done_resp = done_resp_r;
  assign done_err  = done_err_r;

  assign ARID    = id_r;
  assign ARADDR  = addr_r;
  assign ARLEN   = len_r;
  assign ARSIZE  = SIZE_8B;
  assign ARBURST = BURST_INCR;
  assign ARVALID = arvalid_r;
  assign AWID    = id_r;
  assign AWADDR  = addr_r;
  assign AWLEN   = len_r;
  assign AWSIZE  = SIZE_8B;
  assign AWBURST = BURST_INCR;
  assign AWVALID = awvalid_r;
  assign BREADY  = bready_r;

  assign WDATA    = wr_data;
  assign WSTRB    = wr_strb;
  assign WVALID   = (state_r == ST_W) && wr_valid;
  assign WLAST    = (state_r == ST_W) && is_last_s;
  assign wr_ready = (state_r == ST_W) && WREADY;

  assign rd_data  = RDATA;
  assign rd_resp  = RRESP;
  assign rd_last  = RLAST;
  assign rd_valid = (state_r == ST_R) && RVALID;
  assign RREADY   = (state_r == ST_R) && rd_ready;

endmodule

// File: doc/axi_manager.md
# axi_manager

AXI4 manager (initiator) that drives the memory controller's AXI subordinate port from a simple local command interface. It issues one INCR burst at a time (read or write) with 64-bit beats, streams write data from a local source, and forwards read data to a local sink. On completion it reports one response word per transaction. It is used by the on-chip host/test harness and as the bring-up path for the DDR controller.

## Interface
Parameters
- ID_W, 2, AXI ID width
- ADDR_W, 32, address width
- DATA_W, 64, data width; STRB_W = DATA_W/8

Ports
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid / cmd_ready  in/out  1  local command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start byte address, 8-byte aligned
- cmd_len  in  8  beats minus one (AXLEN)
- cmd_id  in  ID_W  transaction ID
- wr_data / wr_strb  in  DATA_W / STRB_W  local write beat
- wr_valid / wr_ready  in/out  1  local write-data handshake
- rd_data / rd_resp / rd_last  out  DATA_W / 2 / 1  local read beat
- rd_valid / rd_ready  out/in  1  local read-data handshake
- done  out  1  one-cycle completion pulse
- done_resp  out  2  worst response seen in transaction
- done_err  out  1  protocol error (ID mismatch or LAST misplacement)
- AR*: ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID out; ARREADY in
- R*: RID, RDATA, RRESP, RLAST, RVALID in; RREADY out
- AW*: AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID out; AWREADY in
- W*: WDATA, WSTRB, WLAST, WVALID out; WREADY in
- B*: BID, BRESP, BVALID in; BREADY out

## Operation
- FSM states: IDLE, AR, R, AW, W, B.
- IDLE: cmd_ready = 1. On cmd_valid: latch addr/len/id; go to AR (read) or AW (write); beat counter cleared, err/resp accumulators cleared.
- AR / AW: xVALID = 1, fields from latched command, xSIZE = 3'b011, xBURST = INCR (2'b01). Hold stable until xREADY; then R or W.
- W: WDATA/WSTRB = wr_data/wr_strb, WVALID = wr_valid, wr_ready = WREADY (combinational pass-through, gated by state). Each W handshake increments beat counter; WLAST = (beat == len). After the WLAST handshake go to B.
- B: BREADY = 1. On BVALID: resp = BRESP, err |= (BID != id); go to IDLE and pulse done.
- R: rd_* = R*, rd_valid = RVALID, RREADY = rd_ready. Each handshake increments beat counter (saturates at 255), resp = max(resp, RRESP), err |= (RID != id) | (RLAST != (beat == len)). Transaction ends on the RLAST handshake → IDLE, pulse done. No RLAST after beat len: keep accepting until RLAST; err set.
- Outside their states all xVALID/xREADY outputs are 0; rd_valid = 0, wr_ready = 0.
- Response ordering: max() over 2-bit codes (OKAY < EXOKAY < SLVERR < DECERR).

## Timing
- Reset: state IDLE; ARVALID, AWVALID, WVALID, RREADY, BREADY, done, done_err = 0; done_resp = 0; address/ID/len outputs = 0; cmd_ready = 1 from the first post-reset cycle.
- Reset mid-burst: next edge returns to IDLE, all valids/readies drop, no done pulse; the subordinate side is reset together.
- Command accepted at edge N → ARVALID/AWVALID high in cycle N+1 (minimum).
- Address handshake at edge M → first R/W beat can complete at edge M+1.
- done, done_resp, done_err are registered: valid in the cycle after the final RLAST or B handshake (state IDLE); a new command may be accepted in that same cycle.
- Address-channel outputs are registers; W and R data paths have zero added latency.
- Single outstanding transaction; no AW/W overlap.

## Structure
- Shared package axi_pkg: burst_t (FIXED/INCR/WRAP), resp_t (OKAY/EXOKAY/SLVERR/DECERR), SIZE_8B = 3'b011, mgr_state_t enum.
- One sub-module: axi_beat_tracker (clear, step, len → beat count, is_last, saturation), instantiated once and shared between W and R states.

## Test plan
- Read len=3, addr 0x0000_0100, id=2, subordinate returns 4 beats OKAY, RLAST on beat 3 → 4 rd beats, rd_last on 4th, done with resp 0, err 0.
- Write len=7, wr_valid toggled every other cycle, WREADY held low 3 cycles mid-burst → exactly 8 W beats, WLAST only on 8th, BREADY high after, done resp 0.
- Read len=1, second beat RRESP=SLVERR → done_resp = 2'b10, done_err = 0.
- Read len=2 with RLAST on beat 1 → transaction ends after 2 beats, done_err = 1; BID=1 vs id=3 on a write → done_err = 1.
- ARREADY held low 10 cycles → ARVALID/ARADDR/ARLEN stable all 10 cycles; rst asserted during W beat 2 → all valids 0 next cycle, no done, cmd_ready = 1.
- Back-to-back: new cmd_valid held during done cycle → accepted in that cycle, ARVALID next cycle.
